decoder_scan_seq: RTL
=====================

DECODER_SCAN_SEQ -- requirements
Module: decoder_scan_seq

Interface
REQ-001 Parameter SEL_W, default 2: select width in bits; legal range 1..6.
REQ-002 Parameter NUM_OUT, default 4: number of one-hot outputs; legal range 2..2**SEL_W.
REQ-003 Parameter DWELL, default 4: idle cycles between scan beats; legal range 1..255.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port en, input, 1 bit: decode enable.
REQ-007 Port mode, input, 1 bit: 0 = direct decode, 1 = auto-scan.
REQ-008 Port in_valid, input, 1 bit: a select value is presented on d.
REQ-009 Port in_ready, output, 1 bit: the block accepts d this cycle.
REQ-010 Port d, input, SEL_W bits: select index.
REQ-011 Port out_valid, output, 1 bit: the output beat on y/idx/err is valid.
REQ-012 Port out_ready, input, 1 bit: the sink accepts the output beat.
REQ-013 Port y, output, NUM_OUT bits: registered one-hot decode result.
REQ-014 Port idx, output, SEL_W bits: index that produced y.
REQ-015 Port err, output, 1 bit: the index was out of range.

Function
REQ-016 The block SHALL be a two-state FSM with states DIRECT and SCAN; the output register holds exactly one beat.
REQ-017 A beat SHALL be accepted when out_valid=1 and out_ready=1 in the same cycle.
REQ-018 In DIRECT, in_ready SHALL equal (!out_valid | out_ready); in SCAN, in_ready SHALL be 0.
REQ-019 DIRECT input transfer: when in_valid=1 and in_ready=1, the block SHALL load the output register at the next edge with the following values.
- en=1 and d<NUM_OUT: y = 1<<d, idx = d, err = 0.
- en=1 and d>=NUM_OUT: y = 0, idx = d, err = 1.
- en=0: y = 0, idx = d, err = 0.
- In all three cases out_valid = 1.
- Latency from accepted input to valid output is 1 cycle.
REQ-020 If a beat is accepted in the same cycle a new input is loaded, the new beat SHALL replace it with no bubble, giving full throughput.
REQ-021 If a beat is accepted and nothing is loaded, out_valid SHALL clear at the next edge; y, idx and err SHALL hold their last values.
REQ-022 While out_valid=1 and out_ready=0, y, idx and err SHALL be stable.
REQ-023 DIRECT to SCAN transition: when mode=1, en=1, no input transfer occurs, and the output register is free (!out_valid | out_ready), the FSM SHALL enter SCAN.
- At that same edge it SHALL load y=1, idx=0, err=0, out_valid=1.
- It SHALL clear the dwell counter.
REQ-024 SCAN dwell: after each scan beat is accepted, an 8-bit dwell counter SHALL count cycles with out_valid=0.
- When the counter reaches DWELL-1, the next edge SHALL load the next index (idx+1, wrapping NUM_OUT-1 to 0) with y = 1<<idx and err = 0.
- The counter SHALL then reset to 0.
REQ-025 Scan beats SHALL be spaced exactly DWELL idle cycles apart when out_ready is held at 1; backpressure SHALL stall the scan without skipping any index.
REQ-026 SCAN to DIRECT transition: when mode=0 or en=0 in SCAN, the FSM SHALL return to DIRECT at the next edge.
- A pending beat SHALL remain valid until it is accepted.
- The dwell counter SHALL clear.
- No further scan beat SHALL be generated.
REQ-027 Within SCAN, the abort condition (REQ-026) SHALL take priority over a dwell-expiry load in the same cycle.
REQ-028 A change of mode while in DIRECT with a pending beat SHALL delay SCAN entry until the output register is free (REQ-023).

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL set the following at that edge, regardless of any other input.
- FSM = DIRECT, dwell counter = 0.
- out_valid = 0, y = 0, idx = 0, err = 0.
- Any pending beat SHALL be discarded.
REQ-030 While rst=1, in_ready SHALL be 0; the first transfer is possible in the cycle after rst deasserts.

Verification
REQ-031 The bench SHALL cover the following directed scenarios.
- Defaults, mode=0, en=1, out_ready=1, d=0,1,2,3 presented back-to-back: y=0001,0010,0100,1000 on consecutive cycles, each 1 cycle after its input.
- NUM_OUT=3, SEL_W=2, en=1, d=3: y=000, idx=3, err=1; en=0, d=1: y=000, err=0.
- Backpressure, out_ready=0 for 3 cycles after d=2 is loaded: y=0100 held stable, in_ready=0; on release the next input loads with no bubble.
- DWELL=2, mode=1, en=1, out_ready=1: idx sequence 0,1,2,3,0 with each beat one cycle long and 2 idle cycles between beats.
- Scan with mode dropped to 0 while a beat is pending and out_ready=0: the beat is held and then accepted; no further scan beats; DIRECT input accepted afterwards.
- rst=1 asserted mid-scan with out_valid=1: next cycle out_valid=0, y=0, idx=0, FSM=DIRECT.

Source files
------------

// File: rtl/decoder_scan_seq.sv
// rtl/decoder_scan_seq.sv - one-hot decoder with a single-beat output register and an auto-scan mode
module decoder_scan_seq #(
    parameter int SEL_W   = 2,
    parameter int NUM_OUT = 4,
    parameter int DWELL   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   d,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] y,
    output logic [SEL_W-1:0]   idx,
    output logic               err
);

    typedef enum logic {
        ST_DIRECT = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // One extra bit so NUM_OUT == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   NUM_OUT_W  = (SEL_W + 1)'(NUM_OUT);
    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_OUT - 1);
    localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [NUM_OUT-1:0] y_q, y_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic [7:0]         cnt_q, cnt_d;

    logic               slot_free;
    logic               beat_taken;
    logic               xfer;
    logic               in_range;
    logic [SEL_W-1:0]   next_idx;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        y_d        = y_q;
        idx_d      = idx_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        slot_free  = !valid_q || out_ready;
        beat_taken = valid_q && out_ready;
        in_ready   = !rst && (state_q == ST_DIRECT) && slot_free;
        xfer       = in_valid && in_ready;
        in_range   = {1'b0, d} < NUM_OUT_W;
        next_idx   = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);

        if (beat_taken) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_DIRECT: begin
                if (xfer) begin
                    valid_d = 1'b1;
                    idx_d   = d;
                    err_d   = en && !in_range;
                    y_d     = (en && in_range) ? (NUM_OUT'(1) << d) : '0;
                end else if (mode && en && slot_free) begin
                    state_d = ST_SCAN;
                    valid_d = 1'b1;
                    y_d     = NUM_OUT'(1);
                    idx_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                // Abort wins over a dwell expiry; a pending beat stays until taken.
                if (!mode || !en) begin
                    state_d = ST_DIRECT;
                    cnt_d   = '0;
                end else if (!valid_q) begin
                    if (cnt_q == DWELL_LAST) begin
                        valid_d = 1'b1;
                        idx_d   = next_idx;
                        y_d     = NUM_OUT'(1) << next_idx;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_DIRECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DIRECT;
            valid_q <= 1'b0;
            y_q     <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign y         = y_q;
    assign idx       = idx_q;
    assign err       = err_q;

endmodule
